uc_eng_port: RTL and testbench

- Per-engine endpoint of the unit-clause interface; the engine-side counterpart of the UC arbiter.
- Buffers implied literals from one BCP engine in an outbound FIFO. Presents them to the arbiter in mask mode (sequential engmask polling) or PQ mode (valid/grant).
- Receives broadcast unit clauses from the arbiter into an inbound FIFO for the engine, and reports back-pressure on that FIFO.
- One instance per engine inside the engine wrapper.

---
 rtl/uc_eng_port.sv | 168 ++++++++++++++++
 tb/tb_uc_eng_port.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uc_eng_port.sv
// Engine-side endpoint of the unit-clause interface: an outbound FIFO of implied literals
// for the UC arbiter and an inbound FIFO of broadcast unit clauses for the BCP engine.
module uc_eng_port #(
    parameter int LIT_IDX_MAX = 255,
    parameter int LIT_W       = $clog2(LIT_IDX_MAX) + 1,
    parameter int OUTQ_DEPTH  = 8,
    parameter int INQ_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_mode,
    input  logic             sel,
    input  logic             uca_ack,
    input  logic             pq_grant,
    input  logic             conflict,
    input  logic             start,
    output logic             eng2uca_valid,
    output logic             eng2uca_empty,
    output logic [LIT_W-1:0] eng2uca_lit,
    input  logic             uca2eng_push,
    input  logic [LIT_W-1:0] uca2eng_lit,
    output logic             port_full,
    input  logic             eng_imp_valid,
    input  logic [LIT_W-1:0] eng_imp_lit,
    output logic             eng_imp_ready,
    output logic             eng_uc_valid,
    output logic [LIT_W-1:0] eng_uc_lit,
    input  logic             eng_uc_ready,
    output logic             overflow,
    output logic             halted
);

    localparam int OUT_AW = $clog2(OUTQ_DEPTH);
    localparam int IN_AW  = $clog2(INQ_DEPTH);
    localparam logic [OUT_AW:0] OUT_FULL = OUTQ_DEPTH[OUT_AW:0];
    localparam logic [IN_AW:0]  IN_FULL  = INQ_DEPTH[IN_AW:0];
    localparam logic [IN_AW:0]  IN_ALMOST = IN_FULL - 1'b1;

    typedef enum logic {ACTIVE = 1'b0, HALT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [OUT_AW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [OUT_AW:0]   out_cnt_q, out_cnt_d;
    logic [IN_AW-1:0]  in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [IN_AW:0]    in_cnt_q, in_cnt_d;
    logic              overflow_q, overflow_d;

    logic [LIT_W-1:0]  outq_mem_q [OUTQ_DEPTH];
    logic [LIT_W-1:0]  inq_mem_q  [INQ_DEPTH];

    logic active, flush, resume;
    logic out_we, out_pop, out_nonempty;
    logic in_push, in_we, in_pop, in_full, in_drop;

    // ---------------- control state ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        flush   = 1'b0;
        resume  = 1'b0;
        unique case (state_q)
            ACTIVE: if (conflict) begin
                state_d = HALT;
                flush   = 1'b1;
            end
            HALT: if (start && !conflict) begin
                state_d = ACTIVE;
                resume  = 1'b1;
            end
        endcase
    end

    assign active = (state_q == ACTIVE);
    assign halted = (state_q == HALT);

    // ---------------- outbound path ----------------
    assign out_nonempty  = (out_cnt_q != '0);
    assign eng_imp_ready = active && (out_cnt_q != OUT_FULL);
    // A zero literal completes the handshake but is never stored.
    assign out_we        = eng_imp_valid && eng_imp_ready && (eng_imp_lit != '0);
    assign eng2uca_empty = !out_nonempty || !active;
    assign eng2uca_valid = input_mode && active && out_nonempty;
    assign eng2uca_lit   = out_nonempty ? outq_mem_q[out_rptr_q] : '0;
    assign out_pop       = input_mode ? (eng2uca_valid && pq_grant)
                                      : (sel && uca_ack && !eng2uca_empty);

    always_comb begin
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        if (out_we)  out_wptr_d = out_wptr_q + 1'b1;
        if (out_pop) out_rptr_d = out_rptr_q + 1'b1;
        unique case ({out_we, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
        if (flush) begin
            out_wptr_d = '0;
            out_rptr_d = '0;
            out_cnt_d  = '0;
        end
    end

    // ---------------- inbound path ----------------
    assign in_full      = (in_cnt_q == IN_FULL);
    assign eng_uc_valid = active && (in_cnt_q != '0);
    assign eng_uc_lit   = (in_cnt_q != '0) ? inq_mem_q[in_rptr_q] : '0;
    assign in_pop       = eng_uc_valid && eng_uc_ready;
    assign in_push      = uca2eng_push && active && (uca2eng_lit != '0);
    assign in_we        = in_push && (!in_full || in_pop);
    assign in_drop      = in_push && in_full && !in_pop;
    // One slot of slack: the arbiter keeps broadcasting until every engine reports full.
    assign port_full    = (in_cnt_q >= IN_ALMOST);
    assign overflow     = overflow_q;

    always_comb begin
        in_wptr_d = in_wptr_q;
        in_rptr_d = in_rptr_q;
        in_cnt_d  = in_cnt_q;
        if (in_we)  in_wptr_d = in_wptr_q + 1'b1;
        if (in_pop) in_rptr_d = in_rptr_q + 1'b1;
        unique case ({in_we, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + 1'b1;
            2'b01:   in_cnt_d = in_cnt_q - 1'b1;
            default: in_cnt_d = in_cnt_q;
        endcase
        if (flush) begin
            in_wptr_d = '0;
            in_rptr_d = '0;
            in_cnt_d  = '0;
        end
        overflow_d = overflow_q;
        if (resume)       overflow_d = 1'b0;
        else if (in_drop) overflow_d = 1'b1;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= ACTIVE;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage arrays are not reset; counts gate every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (out_we) outq_mem_q[out_wptr_q] <= eng_imp_lit;
        if (in_we)  inq_mem_q[in_wptr_q]   <= uca2eng_lit;
    end

endmodule

// File: tb/tb_uc_eng_port.sv
// Directed self-checking bench for uc_eng_port: mask/PQ outbound, inbound full/overflow,
// HALT flush and restart, and asynchronous reset with a full outbound FIFO.
module tb_uc_eng_port;

    localparam int LIT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             input_mode, sel, uca_ack, pq_grant, conflict, start;
    logic             eng2uca_valid, eng2uca_empty;
    logic [LIT_W-1:0] eng2uca_lit;
    logic             uca2eng_push;
    logic [LIT_W-1:0] uca2eng_lit;
    logic             port_full;
    logic             eng_imp_valid;
    logic [LIT_W-1:0] eng_imp_lit;
    logic             eng_imp_ready, eng_uc_valid;
    logic [LIT_W-1:0] eng_uc_lit;
    logic             eng_uc_ready, overflow, halted;

    int n_vec = 0;
    int n_bad = 0;

    uc_eng_port #(.LIT_W(LIT_W), .OUTQ_DEPTH(8), .INQ_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .input_mode(input_mode), .sel(sel), .uca_ack(uca_ack),
        .pq_grant(pq_grant), .conflict(conflict), .start(start),
        .eng2uca_valid(eng2uca_valid), .eng2uca_empty(eng2uca_empty), .eng2uca_lit(eng2uca_lit),
        .uca2eng_push(uca2eng_push), .uca2eng_lit(uca2eng_lit), .port_full(port_full),
        .eng_imp_valid(eng_imp_valid), .eng_imp_lit(eng_imp_lit), .eng_imp_ready(eng_imp_ready),
        .eng_uc_valid(eng_uc_valid), .eng_uc_lit(eng_uc_lit), .eng_uc_ready(eng_uc_ready),
        .overflow(overflow), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [LIT_W-1:0] lit(input int v);
        return LIT_W'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic out_write(input int v);
        eng_imp_valid = 1'b1;
        eng_imp_lit   = lit(v);
        tick();
        eng_imp_valid = 1'b0;
        eng_imp_lit   = '0;
    endtask

    task automatic in_push(input int v, input logic rdy);
        uca2eng_push = 1'b1;
        uca2eng_lit  = lit(v);
        eng_uc_ready = rdy;
        tick();
        uca2eng_push = 1'b0;
        uca2eng_lit  = '0;
        eng_uc_ready = 1'b0;
    endtask

    task automatic mask_pop;
        sel     = 1'b1;
        uca_ack = 1'b1;
        tick();
        uca_ack = 1'b0;
    endtask

    initial begin
        int drain_exp [8];
        drain_exp = '{2, 3, 4, 5, 6, 7, 8, 6};

        rst_n = 1'b0;
        input_mode = 1'b0; sel = 1'b0; uca_ack = 1'b0; pq_grant = 1'b0;
        conflict = 1'b0; start = 1'b0; uca2eng_push = 1'b0; uca2eng_lit = '0;
        eng_imp_valid = 1'b0; eng_imp_lit = '0; eng_uc_ready = 1'b0;
        #2;
        check("rst_valid",     eng2uca_valid, 0);
        check("rst_empty",     eng2uca_empty, 1);
        check("rst_lit",       eng2uca_lit,   0);
        check("rst_port_full", port_full,     0);
        check("rst_imp_ready", eng_imp_ready, 1);
        check("rst_uc_valid",  eng_uc_valid,  0);
        check("rst_uc_lit",    eng_uc_lit,    0);
        check("rst_overflow",  overflow,      0);
        check("rst_halted",    halted,        0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Mask mode: 5, -3, 7 and a discarded zero literal.
        out_write(5); out_write(-3); out_write(7); out_write(0);
        check("mask_head0",  eng2uca_lit,   lit(5));
        check("mask_nempty", eng2uca_empty, 0);
        check("mask_valid0", eng2uca_valid, 0);
        uca_ack = 1'b1; sel = 1'b0;
        tick();
        uca_ack = 1'b0;
        check("mask_nosel",  eng2uca_lit, lit(5));
        mask_pop();
        check("mask_head1",  eng2uca_lit, lit(-3));
        mask_pop();
        check("mask_head2",  eng2uca_lit, lit(7));
        mask_pop();
        check("mask_empty",  eng2uca_empty, 1);
        check("mask_lit0",   eng2uca_lit,   0);
        sel = 1'b0;

        // PQ mode: grant low three cycles, then held high.
        input_mode = 1'b1;
        out_write(4); out_write(-9);
        for (int i = 0; i < 3; i++) begin
            check("pq_wait_valid", eng2uca_valid, 1);
            check("pq_wait_lit",   eng2uca_lit,   lit(4));
            tick();
        end
        pq_grant = 1'b1;
        tick();
        check("pq_second_valid", eng2uca_valid, 1);
        check("pq_second_lit",   eng2uca_lit,   lit(-9));
        tick();
        check("pq_drained", eng2uca_valid, 0);
        pq_grant = 1'b0;
        input_mode = 1'b0;

        // Inbound: fill to depth, then full push with same-cycle pop.
        for (int i = 1; i <= 8; i++) begin
            in_push(i, 1'b0);
            if (i == 6) check("in_pf_after6", port_full, 0);
            if (i == 7) check("in_pf_after7", port_full, 1);
        end
        check("in_full_head",  eng_uc_lit,   lit(1));
        check("in_full_valid", eng_uc_valid, 1);
        in_push(6, 1'b1);
        check("in_fullpop_ovf", overflow,  0);
        check("in_fullpop_pf",  port_full, 1);
        eng_uc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("in_drain", eng_uc_lit, lit(drain_exp[i]));
            tick();
        end
        check("in_drained", eng_uc_valid, 0);
        eng_uc_ready = 1'b0;

        // Inbound overflow on a ninth push without a pop.
        for (int i = 1; i <= 8; i++) in_push(i, 1'b0);
        in_push(9, 1'b0);
        check("ovf_set",  overflow,   1);
        check("ovf_head", eng_uc_lit, lit(1));

        // Leave 2 inbound and 3 outbound entries, then conflict.
        eng_uc_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        eng_uc_ready = 1'b0;
        check("pre_halt_inhead", eng_uc_lit, lit(7));
        out_write(11); out_write(12); out_write(13);
        check("pre_halt_outhead", eng2uca_lit, lit(11));
        conflict = 1'b1;
        tick();
        conflict = 1'b0;
        check("halt_halted",    halted,        1);
        check("halt_empty",     eng2uca_empty, 1);
        check("halt_uc_valid",  eng_uc_valid,  0);
        check("halt_imp_ready", eng_imp_ready, 0);
        check("halt_ovf_kept",  overflow,      1);
        in_push(20, 1'b0);
        out_write(21);
        conflict = 1'b1; start = 1'b1;
        tick();
        conflict = 1'b0;
        check("halt_conflict_prio", halted, 1);
        tick();
        start = 1'b0;
        check("resume_halted",   halted,        0);
        check("resume_empty",    eng2uca_empty, 1);
        check("resume_lit",      eng2uca_lit,   0);
        check("resume_uc_valid", eng_uc_valid,  0);
        check("resume_ovf",      overflow,      0);
        check("resume_ready",    eng_imp_ready, 1);

        // Full outbound: pop does not raise ready in the same cycle.
        for (int i = 1; i <= 8; i++) out_write(i);
        check("outfull_ready", eng_imp_ready, 0);
        sel = 1'b1; uca_ack = 1'b1;
        #1;
        check("outfull_pop_ready", eng_imp_ready, 0);
        tick();
        uca_ack = 1'b0; sel = 1'b0;
        check("outfull_after_pop", eng_imp_ready, 1);
        check("outfull_head2",     eng2uca_lit,   lit(2));
        out_write(30);

        // Asynchronous reset mid-cycle with outbound full.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_empty",  eng2uca_empty, 1);
        check("arst_lit",    eng2uca_lit,   0);
        check("arst_ready",  eng_imp_ready, 1);
        check("arst_valid",  eng2uca_valid, 0);
        check("arst_halted", halted,        0);
        check("arst_pf",     port_full,     0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
